// File: rtl/ai_cache_refill_ctrl.sv
// Read-miss refill controller: one outstanding line read, fill strobe, completion pulse.
// Optional wait-state timeout is compiled in with `define REFILL_TIMEOUT_EN.
module ai_cache_refill_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic                  fill_en,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic [15:0]           refill_count
);

  // state  | meaning
  // IDLE   | ready for a miss, memory responses ignored
  // REQ    | line read request presented to memory
  // WAIT   | request accepted, waiting for the response
  // FILL   | one-cycle fill strobe plus good completion
  // ERR    | one-cycle error completion, no fill
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_ERR} state_t;

  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) || (DATA_WIDTH < 8)) begin : g_bad_params
  end

  state_t                r_state;
  logic                  r_miss_ready;
  logic                  r_mem_req_valid;
  logic [ADDR_WIDTH-1:0] r_line_addr;
  logic                  r_fill_en;
  logic [DATA_WIDTH-1:0] r_fill_data;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_err;
  logic                  r_busy;
  logic [15:0]           r_refill_count;
  logic [ADDR_WIDTH-1:0] w_aligned;

`ifdef REFILL_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wait_cnt;
`endif

  assign w_aligned = miss_addr & LINE_MASK;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_miss_ready    <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_line_addr     <= '0;
      r_fill_en       <= 1'b0;
      r_fill_data     <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
      r_resp_err      <= 1'b0;
      r_busy          <= 1'b0;
      r_refill_count  <= '0;
`ifdef REFILL_TIMEOUT_EN
      r_wait_cnt      <= '0;
`endif
    end else begin
      r_fill_en    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss_valid) begin
            r_line_addr     <= w_aligned;
            r_state         <= S_REQ;
            r_miss_ready    <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_busy          <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_state         <= S_WAIT;
            r_mem_req_valid <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
            r_wait_cnt      <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_err) begin
              r_state      <= S_ERR;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= '0;
            end else begin
              r_state      <= S_FILL;
              r_fill_en    <= 1'b1;
              r_resp_valid <= 1'b1;
              r_fill_data  <= mem_rsp_data;
              r_resp_data  <= mem_rsp_data;
            end
          end
`ifdef REFILL_TIMEOUT_EN
          // a response on the limit cycle wins because it is tested first
          else if (r_wait_cnt == TMO_LAST) begin
            r_state      <= S_ERR;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_data  <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
`endif
        end
        S_FILL: begin
          r_state      <= S_IDLE;
          r_miss_ready <= 1'b1;
          r_busy       <= 1'b0;
          if (r_refill_count != 16'hFFFF) r_refill_count <= r_refill_count + 16'd1;
        end
        S_ERR: begin
          r_state      <= S_IDLE;
          r_miss_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state         <= S_IDLE;
          r_miss_ready    <= 1'b1;
          r_mem_req_valid <= 1'b0;
          r_busy          <= 1'b0;
        end
      endcase
    end
  end

  assign miss_ready    = r_miss_ready;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_line_addr;
  assign fill_en       = r_fill_en;
  assign fill_addr     = r_line_addr;
  assign fill_data     = r_fill_data;
  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign resp_err      = r_resp_err;
  assign busy          = r_busy;
  assign refill_count  = r_refill_count;

endmodule

// File: doc/ai_cache_refill_ctrl.md
Name: ai_cache_refill_ctrl

Overview:
Miss-handling stage directly downstream of ai_cache. It accepts one read-miss at a time, issues a line-aligned read to backing memory over a valid/ready request channel, and waits for the response. It then writes the returned line into the cache through a one-cycle fill strobe and returns the data to the requester. It also keeps a saturating count of successful refills.

Parameters:
ADDR_WIDTH, 32, byte address width; must match ai_cache.
DATA_WIDTH, 128, line width in bits; must be a power of two and at least 8.
TIMEOUT_CYCLES, 64, wait limit used only when the optional feature is compiled in; range 1 to 65535.

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
miss_valid  in  1  cache presents a read miss
miss_ready  out  1  controller can accept a miss
miss_addr  in  ADDR_WIDTH  byte address of the missing access
mem_req_valid  out  1  memory read request valid
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  ADDR_WIDTH  line-aligned request address
mem_rsp_valid  in  1  memory response valid; no backpressure
mem_rsp_data  in  DATA_WIDTH  returned line
mem_rsp_err  in  1  memory error flag, qualified by mem_rsp_valid
fill_en  out  1  one-cycle write strobe into the cache array
fill_addr  out  ADDR_WIDTH  line-aligned fill address
fill_data  out  DATA_WIDTH  fill line
resp_valid  out  1  one-cycle completion pulse to the requester
resp_data  out  DATA_WIDTH  line returned to the requester
resp_err  out  1  completion carries an error, qualified by resp_valid
busy  out  1  high in any state other than IDLE
refill_count  out  16  saturating count of successful fills

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - mem_req_valid, fill_en, resp_valid, resp_err, busy are all 0.
  - refill_count, mem_req_addr, fill_addr, fill_data, resp_data are all 0.
  - miss_ready is 1 from the first cycle after reset is released.
  - Reset mid-transaction abandons the transaction: no fill, no response. Any memory response arriving afterwards in IDLE is ignored.
- Alignment: OFF = log2(DATA_WIDTH/8). The latched address has bits [OFF-1:0] forced to 0; this value drives both mem_req_addr and fill_addr.
- FSM:
  - IDLE: miss_ready=1. If miss_valid, latch the aligned address and go to REQ. mem_rsp_valid is ignored in IDLE.
  - REQ: mem_req_valid=1 and mem_req_addr is held stable. When mem_req_ready==1 go to WAIT. mem_rsp_valid in REQ is spurious and ignored.
  - WAIT: on mem_rsp_valid, register mem_rsp_data.
    - If mem_rsp_err==1: go to ERR.
    - Otherwise: go to FILL.
  - FILL (one cycle): fill_en=1, resp_valid=1, resp_err=0, fill_data=resp_data=captured line. refill_count increments unless it is 0xFFFF. Next state is IDLE.
  - ERR (one cycle): resp_valid=1, resp_err=1, fill_en=0, resp_data=0, refill_count unchanged. Next state is IDLE.
- miss_ready=0 in every state except IDLE. A miss_valid held during that time stays pending and is accepted on return to IDLE.
- Latency with zero-wait memory (miss accepted at cycle 0, mem_req_ready already high, response N cycles after entering WAIT):
  - REQ at cycle 1, WAIT at cycle 2.
  - FILL at cycle 2+N+1.
  - Back in IDLE, accepting the next miss, the cycle after that.
  - With a one-cycle response (N=1), fill_en is at cycle 4.
- busy equals (state != IDLE). fill_en and resp_valid are never high for more than one consecutive cycle per miss.

Optional Feature:
Macro REFILL_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to WAIT and increments every WAIT cycle without mem_rsp_valid.
  - When the count reaches TIMEOUT_CYCLES with no response, go to ERR (resp_err=1, no fill).
  - A response on the same cycle the limit is hit takes priority and is handled normally.
  - Responses arriving after the timeout are ignored in IDLE.
- Not defined: the counter is absent, and WAIT holds indefinitely until mem_rsp_valid.

Test Plan:
- Basic refill: reset low 2 cycles, release; miss_addr=0x0000_003C; mem_req_ready=1; response data 0x...1234 one cycle after WAIT -> mem_req_addr=0x0000_0030; fill_en one cycle with fill_addr=0x30 and fill_data=0x1234; resp_valid with same data; refill_count=1.
- Request backpressure: mem_req_ready low 5 cycles -> mem_req_valid high and mem_req_addr stable all 5 cycles; exactly one accepted request; miss_ready low throughout.
- Memory error: response with mem_rsp_err=1 -> resp_valid=1, resp_err=1, fill_en never asserted, refill_count unchanged.
- Back-to-back misses: miss_valid held high with addr 0x100 then 0x210 -> two fills at 0x100 and 0x210; second accepted the cycle after the first FILL; refill_count=2; spurious mem_rsp_valid during REQ ignored.
- Reset mid-WAIT: assert reset during WAIT, then deliver the response after release -> no fill_en, no resp_valid; state IDLE; refill_count=0.
- Timeout (REFILL_TIMEOUT_EN, TIMEOUT_CYCLES=8): no response -> ERR pulse (resp_err=1) exactly 8 cycles after entering WAIT. Without the macro: the controller stays busy for 100 cycles.
